jtframe_dwnld_feeder: RTL

JTFRAME_DWNLD_FEEDER -- requirements
Module: jtframe_dwnld_feeder

---
 rtl/jtframe_dwnld_pkg.sv | 23 ++
 rtl/jtframe_dwnld_gap.sv | 28 ++
 rtl/jtframe_dwnld_feeder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: FSM encoding and gap-counter limits
// shared by the download feeder and its gap counter.
package jtframe_dwnld_pkg;

  localparam int GAP_W      = 8;
  localparam int WR_GAP_MAX = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_GAP,
    ST_FIN
  } dwnld_st_t;

  // The counter is loaded at the write edge, so it holds gap-1.
  function automatic logic [GAP_W-1:0] gap_load(input int gap);
    int g;
    g = (gap > WR_GAP_MAX) ? WR_GAP_MAX : gap;
    return (g > 0) ? GAP_W'(g - 1) : '0;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_gap.sv
// jtframe_dwnld_gap: loadable down-counter that flags zero,
// used to pace idle cycles between ioctl writes.
module jtframe_dwnld_gap
  import jtframe_dwnld_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [GAP_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - GAP_W'(1);
    end
  end

  assign zero = cnt == '0;

endmodule

// File: rtl/jtframe_dwnld_feeder.sv
// jtframe_dwnld_feeder: copies rom_len bytes from a source to the ioctl port.
// Define DWNLD_CHECKSUM_EN to add the 16-bit running checksum output.
module jtframe_dwnld_feeder
  import jtframe_dwnld_pkg::*;
#(
  parameter int AW     = 25,
  parameter int WR_GAP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] rom_len,
  output logic [AW-1:0] src_addr,
  output logic          src_rd,
  input  logic [7:0]    src_data,
  input  logic          src_ok,
  input  logic          dwnld_busy,
  output logic          downloading,
  output logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_dout,
  output logic          ioctl_wr,
  output logic          done
`ifdef DWNLD_CHECKSUM_EN
  ,
  output logic [15:0]   checksum
`endif
);

  localparam logic [GAP_W-1:0] GAP_LD = gap_load(WR_GAP);
  localparam bit               NO_GAP = WR_GAP == 0;

  dwnld_st_t     st, st_nx;
  logic [AW-1:0] idx;
  logic [AW-1:0] left;
  logic          accept;
  logic          take;
  logic          gap_ld;
  logic          gap_en;
  logic          gap_zero;

  assign accept   = st == ST_IDLE && start;
  assign take     = st == ST_FETCH && src_ok;
  assign src_addr = idx;

  jtframe_dwnld_gap u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_ld),
    .load_val (GAP_LD),
    .en       (gap_en),
    .zero     (gap_zero)
  );

  always_comb begin
    st_nx    = st;
    src_rd   = 1'b0;
    ioctl_wr = 1'b0;
    gap_ld   = 1'b0;
    gap_en   = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (start) begin
          st_nx = (rom_len != '0) ? ST_FETCH : ST_FIN;
        end
      end
      ST_FETCH: begin
        src_rd = 1'b1;
        if (src_ok) begin
          st_nx = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!dwnld_busy) begin
          ioctl_wr = 1'b1;
          if (!NO_GAP) begin
            gap_ld = 1'b1;
            st_nx  = ST_GAP;
          end else begin
            st_nx = (left == AW'(1)) ? ST_FIN : ST_FETCH;
          end
        end
      end
      ST_GAP: begin
        gap_en = 1'b1;
        // left was already decremented by the write
        if (gap_zero) begin
          st_nx = (left == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FIN: begin
        st_nx = ST_IDLE;
      end
      default: begin
        st_nx = ST_IDLE;
      end
    endcase
  end

  // done and the fall of downloading are registered out of FIN,
  // so both land together in the cycle after FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_IDLE;
      idx         <= '0;
      left        <= '0;
      ioctl_addr  <= '0;
      ioctl_dout  <= '0;
      downloading <= 1'b0;
      done        <= 1'b0;
    end else begin
      st   <= st_nx;
      done <= st == ST_FIN;
      if (accept) begin
        idx         <= '0;
        left        <= rom_len;
        downloading <= rom_len != '0;
      end
      if (take) begin
        ioctl_addr <= idx;
        ioctl_dout <= src_data;
      end
      if (ioctl_wr) begin
        idx  <= idx + AW'(1);
        left <= left - AW'(1);
      end
      if (st == ST_FIN) begin
        downloading <= 1'b0;
      end
    end
  end

`ifdef DWNLD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (ioctl_wr) begin
      checksum <= checksum + {8'd0, ioctl_dout};
    end
  end
`endif

endmodule
